// File: rtl/priority_encoder_7seg_stream.sv
// rtl/priority_encoder_7seg_stream.sv - streaming priority encoder, one hex 7-seg beat per set bit (optional PRIO_POPCOUNT_EN)
module priority_encoder_7seg_stream #(
    parameter int WIDTH          = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_index,
    output logic [6:0]       out_segments,
    output logic             out_none,
    output logic             out_last,
`ifdef PRIO_POPCOUNT_EN
    output logic [4:0]       out_remaining,
`endif
    output logic             busy
);

    // Segment value shown while idle/reset: dark on either display polarity.
    localparam logic [6:0] SEG_IDLE = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [WIDTH-1:0] pending;
    logic             capture;
    logic             accept;
    logic             advance;
    logic [WIDTH-1:0] src;
    logic [3:0]       pos;
    logic [WIDTH-1:0] rest;
    logic [6:0]       seg_raw;
    logic [6:0]       seg_drive;

    // Position of the most significant set bit; 0 for an all-zero word.
    function automatic logic [3:0] msb_pos(input logic [WIDTH-1:0] v);
        msb_pos = 4'd0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) msb_pos = 4'(i);
        end
    endfunction

    // Hex digit to {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_seg = 7'b0111111;
            4'h1: hex_seg = 7'b0000110;
            4'h2: hex_seg = 7'b1011011;
            4'h3: hex_seg = 7'b1001111;
            4'h4: hex_seg = 7'b1100110;
            4'h5: hex_seg = 7'b1101101;
            4'h6: hex_seg = 7'b1111101;
            4'h7: hex_seg = 7'b0000111;
            4'h8: hex_seg = 7'b1111111;
            4'h9: hex_seg = 7'b1101111;
            4'hA: hex_seg = 7'b1110111;
            4'hB: hex_seg = 7'b1111100;
            4'hC: hex_seg = 7'b0111001;
            4'hD: hex_seg = 7'b1011110;
            4'hE: hex_seg = 7'b1111001;
            default: hex_seg = 7'b1110001;
        endcase
    endfunction

`ifdef PRIO_POPCOUNT_EN
    logic [4:0] remaining;

    function automatic logic [4:0] popcnt(input logic [WIDTH-1:0] v);
        popcnt = 5'd0;
        for (int i = 0; i < WIDTH; i++) begin
            popcnt = popcnt + 5'(v[i]);
        end
    endfunction

    assign out_remaining = remaining;
`endif

    // Handshake decode and next-beat computation; one encoder serves both capture and advance.
    always_comb begin
        in_ready  = !out_valid || (out_ready && out_last);
        capture   = in_valid && in_ready;
        accept    = out_valid && out_ready;
        advance   = accept && !out_last;
        src       = capture ? in_data : pending;
        pos       = msb_pos(src);
        rest      = src & ~(WIDTH'(1) << pos);
        seg_raw   = (src == '0) ? 7'h00 : hex_seg(pos);
        seg_drive = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
        busy      = out_valid || (pending != '0);
    end

    // Beat register: capture wins over advance/final accept; a stall holds everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_index    <= 4'd0;
            out_segments <= SEG_IDLE;
            out_none     <= 1'b0;
            out_last     <= 1'b0;
            pending      <= '0;
`ifdef PRIO_POPCOUNT_EN
            remaining    <= 5'd0;
`endif
        end else if (capture) begin
            out_valid    <= 1'b1;
            out_index    <= pos;
            out_segments <= seg_drive;
            out_none     <= (in_data == '0);
            out_last     <= (rest == '0);
            pending      <= rest;
`ifdef PRIO_POPCOUNT_EN
            remaining    <= (in_data == '0) ? 5'd1 : popcnt(in_data);
`endif
        end else if (advance) begin
            out_index    <= pos;
            out_segments <= seg_drive;
            out_none     <= 1'b0;
            out_last     <= (rest == '0);
            pending      <= rest;
`ifdef PRIO_POPCOUNT_EN
            remaining    <= remaining - 5'd1;
`endif
        end else if (accept) begin
            out_valid    <= 1'b0;
`ifdef PRIO_POPCOUNT_EN
            remaining    <= 5'd0;
`endif
        end
    end

endmodule

// File: tb/tb_priority_encoder_7seg_stream.sv
// tb/tb_priority_encoder_7seg_stream.sv - self-checking bench for priority_encoder_7seg_stream
module tb_priority_encoder_7seg_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_none, out_last, busy;
    logic [7:0]  in_data;
    logic [3:0]  out_index;
    logic [6:0]  out_segments;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, out_none16, out_last16, busy16;
    logic [15:0] in_data16;
    logic [3:0]  out_index16;
    logic [6:0]  out_segments16;
`ifdef PRIO_POPCOUNT_EN
    logic [4:0]  out_remaining, out_remaining16;
`endif

    always #5 clk = ~clk;

    priority_encoder_7seg_stream #(.WIDTH(8), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .out_segments(out_segments), .out_none(out_none), .out_last(out_last),
`ifdef PRIO_POPCOUNT_EN
        .out_remaining(out_remaining),
`endif
        .busy(busy)
    );

    priority_encoder_7seg_stream #(.WIDTH(16), .SEG_ACTIVE_LOW(1'b1)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
        .out_valid(out_valid16), .out_ready(out_ready16), .out_index(out_index16),
        .out_segments(out_segments16), .out_none(out_none16), .out_last(out_last16),
`ifdef PRIO_POPCOUNT_EN
        .out_remaining(out_remaining16),
`endif
        .busy(busy16)
    );

    typedef struct {
        logic [3:0] idx;
        logic       none;
        logic       last;
    } beat_t;

    beat_t      q[$];
    int         errors = 0;
    int         checks = 0;
    logic [6:0] seg_tab [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                 7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                                 7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: a word expands into its set-bit indices, highest first, or a single none beat.
    task automatic push_word(input logic [7:0] w);
        beat_t b;
        if (w == 8'h00) begin
            b.idx = 4'd0; b.none = 1'b1; b.last = 1'b1;
            q.push_back(b);
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (w[i]) begin
                    b.idx = 4'(i); b.none = 1'b0; b.last = 1'b0;
                    q.push_back(b);
                end
            end
            q[q.size()-1].last = 1'b1;
        end
    endtask

    // One cycle: drive at the falling edge, check, then advance the model past the next rising edge.
    task automatic step(input logic iv, input logic [7:0] d, input logic ordy);
        logic exp_valid, exp_ready;
        int   rem;
        in_valid  = iv;
        in_data   = iv ? d : 8'hxx;
        out_ready = ordy;
        #1;
        exp_valid = (q.size() != 0);
        exp_ready = !exp_valid || (ordy && q[0].last);
        chk("in_ready", {15'd0, in_ready}, {15'd0, exp_ready});
        chk("out_valid", {15'd0, out_valid}, {15'd0, exp_valid});
        chk("busy", {15'd0, busy}, {15'd0, exp_valid});
        rem = 0;
        if (exp_valid) begin
            chk("out_index", {12'd0, out_index}, {12'd0, q[0].idx});
            chk("out_segments", {9'd0, out_segments}, {9'd0, q[0].none ? 7'd0 : seg_tab[q[0].idx]});
            chk("out_none", {15'd0, out_none}, {15'd0, q[0].none});
            chk("out_last", {15'd0, out_last}, {15'd0, q[0].last});
            rem = 1;
            while (!q[rem-1].last) rem++;
        end
`ifdef PRIO_POPCOUNT_EN
        chk("out_remaining", {11'd0, out_remaining}, 16'(rem));
`endif
        if (exp_valid && ordy) void'(q.pop_front());
        if (iv && exp_ready) push_word(d);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            step(1'b0, 8'h00, 1'b1);
            n++;
        end
        chk("drain_bound", 16'(q.size()), 16'd0);
    endtask

    initial begin
        logic [7:0] d;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        in_valid16 = 1'b0; in_data16 = 16'h0000; out_ready16 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_out_segments", {9'd0, out_segments}, 16'd0);
        chk("rst_seg_active_low", {9'd0, out_segments16}, 16'h007F);
        chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
        rst = 1'b0;
        @(negedge clk);

        // 8'hA4 -> 7,5,2
        step(1'b1, 8'hA4, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b1);
        // zero word -> single none beat
        step(1'b1, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        // 8'hC1 stalled for 5 cycles
        step(1'b1, 8'hC1, 1'b0);
        repeat (5) step(1'b0, 8'h00, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b1);
        // back-to-back 8'h10 then 8'h02
        step(1'b1, 8'h10, 1'b1);
        step(1'b1, 8'h02, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 5) == 0) d = 8'h00;
            step(1'($urandom), d, ($urandom_range(0, 3) != 0));
        end
        drain();

        // reset during the first beat of 8'hFF
        step(1'b1, 8'hFF, 1'b1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("midrst_busy", {15'd0, busy}, 16'd0);
`ifdef PRIO_POPCOUNT_EN
        chk("midrst_remaining", {11'd0, out_remaining}, 16'd0);
`endif
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hFF, 1'b1);
        drain();
        in_valid = 1'b0;

        // WIDTH=16, active-low segments, 16'h8001
        in_valid16 = 1'b1; in_data16 = 16'h8001; out_ready16 = 1'b1;
        @(negedge clk);
        in_valid16 = 1'b0; in_data16 = 16'hxxxx;
        chk("w16_b0_valid", {15'd0, out_valid16}, 16'd1);
        chk("w16_b0_index", {12'd0, out_index16}, 16'd15);
        chk("w16_b0_seg", {9'd0, out_segments16}, {9'd0, 7'b0001110});
        chk("w16_b0_last", {15'd0, out_last16}, 16'd0);
        @(negedge clk);
        chk("w16_b1_index", {12'd0, out_index16}, 16'd0);
        chk("w16_b1_seg", {9'd0, out_segments16}, {9'd0, 7'b1000000});
        chk("w16_b1_last", {15'd0, out_last16}, 16'd1);
        @(negedge clk);
        chk("w16_done_valid", {15'd0, out_valid16}, 16'd0);
        chk("w16_done_busy", {15'd0, busy16}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
